// File: rtl/shift_unit_arbiter.sv
// Two-requester round-robin front end for the shared 32-bit combinational shifter.
// Operands and results are registered; one operation is in flight at a time.

module combinational_shifter #(
  parameter int W = 32
) (
  input  logic [W-1:0] data_i,
  input  logic [4:0]   shamt_i,
  input  logic [1:0]   ctrl_i,
  output logic [W-1:0] result_o
);
  always_comb begin
    result_o = data_i;
    case (ctrl_i)
      2'b00: result_o = data_i << shamt_i;
      2'b01: result_o = data_i >> shamt_i;
      2'b10: result_o = $unsigned($signed(data_i) >>> shamt_i);
      // A zero rotate must not evaluate x << W, so it is special-cased.
      2'b11: result_o = (shamt_i == 5'd0) ? data_i :
                        (data_i >> shamt_i) + (data_i << (6'(W) - {1'b0, shamt_i}));
      default: result_o = data_i;
    endcase
  end
endmodule

module shift_unit_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic [W-1:0] a_data,
  input  logic [4:0]   a_shamt,
  input  logic [1:0]   a_ctrl,
  output logic         a_rsp_valid,
  input  logic         a_rsp_ready,
  output logic [W-1:0] a_rsp_data,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic [W-1:0] b_data,
  input  logic [4:0]   b_shamt,
  input  logic [1:0]   b_ctrl,
  output logic         b_rsp_valid,
  input  logic         b_rsp_ready,
  output logic [W-1:0] b_rsp_data,
  output logic         busy,
  output logic         prio_b,
  output logic [15:0]  op_count
);
  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Requesters
  // hold valid and operands stable until the transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t       state_q;
  logic         owner_b_q;
  logic         prio_b_q;
  logic         a_rsp_valid_q;
  logic         b_rsp_valid_q;
  logic [W-1:0] data_q;
  logic [4:0]   shamt_q;
  logic [1:0]   ctrl_q;
  logic [W-1:0] result_q;
  logic [15:0]  op_count_q;

  logic         grant_b;
  logic         take;
  logic         owner_rsp_ready;
  logic [W-1:0] shift_res;

  // B wins when it is the only requester or holds priority.
  assign grant_b         = b_req_valid & (~a_req_valid | prio_b_q);
  assign take            = (state_q == IDLE) & (a_req_valid | b_req_valid);
  assign owner_rsp_ready = owner_b_q ? b_rsp_ready : a_rsp_ready;

  assign a_req_ready = take & ~grant_b;
  assign b_req_ready = take & grant_b;

  combinational_shifter #(.W(W)) u_shifter (
    .data_i   (data_q),
    .shamt_i  (shamt_q),
    .ctrl_i   (ctrl_q),
    .result_o (shift_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_b_q     <= 1'b0;
      prio_b_q      <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      data_q        <= '0;
      shamt_q       <= '0;
      ctrl_q        <= '0;
      result_q      <= '0;
      op_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            data_q    <= grant_b ? b_data  : a_data;
            shamt_q   <= grant_b ? b_shamt : a_shamt;
            ctrl_q    <= grant_b ? b_ctrl  : a_ctrl;
            owner_b_q <= grant_b;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          result_q      <= shift_res;
          a_rsp_valid_q <= ~owner_b_q;
          b_rsp_valid_q <= owner_b_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) begin
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            op_count_q    <= op_count_q + 16'd1;
            prio_b_q      <= ~owner_b_q;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = result_q;
  assign b_rsp_data  = result_q;
  assign busy        = (state_q != IDLE);
  assign prio_b      = prio_b_q;
  assign op_count    = op_count_q;
endmodule
